addsub_rr_scheduler: RTL

//  Time-shares one 8-bit ripple adder/subtractor among NUM_REQ requesters (conv-layer partial-sum units).

---
 rtl/addsub_rr_pkg.sv | 21 ++
 rtl/addsub_rr_scheduler_if.sv | 37 +++
 rtl/rr_grant_pick.sv | 31 +++
 rtl/addsub_rr_scheduler.sv | 128 ++++++++++++
 4 files changed

// File: rtl/addsub_rr_pkg.sv
// Shared types and constants for the round-robin add/sub scheduler.
// Grant-index width helper is reused by other arbiters.
package addsub_rr_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned NUM_REQ_DEF = 4;

  // Index width for an N-way arbiter; never narrower than one bit.
  function automatic int unsigned id_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned ID_W = id_width(NUM_REQ_DEF);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StResp
  } state_e;

endpackage

// File: rtl/addsub_rr_scheduler_if.sv
// Request, result and adder-side signals of the add/sub scheduler.
// slave = scheduler side, master = requester/environment side.
interface addsub_rr_scheduler_if
  import addsub_rr_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF
);
  localparam int unsigned IdW = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        req_sub;

  logic                      au_cin;
  logic [DATA_W-1:0]         au_i0;
  logic [DATA_W-1:0]         au_i1;
  logic [DATA_W-1:0]         au_sum;

  logic                      res_valid;
  logic                      res_ready;
  logic [DATA_W-1:0]         res_data;
  logic [IdW-1:0]            res_id;
  logic                      res_ovf;

  modport slave (
    input  req_valid, req_a, req_b, req_sub, au_sum, res_ready,
    output req_ready, au_cin, au_i0, au_i1, res_valid, res_data, res_id, res_ovf
  );

  modport master (
    output req_valid, req_a, req_b, req_sub, au_sum, res_ready,
    input  req_ready, au_cin, au_i0, au_i1, res_valid, res_data, res_id, res_ovf
  );

endinterface

// File: rtl/rr_grant_pick.sv
// Combinational round-robin pick: first set request searching upward from
// last_i+1, wrapping. Shared with other arbiters.
module rr_grant_pick
  import addsub_rr_pkg::*;
#(
  parameter int unsigned N = NUM_REQ_DEF
) (
  input  logic [N-1:0]            req_i,
  input  logic [id_width(N)-1:0]  last_i,
  output logic                    any_o,
  output logic [id_width(N)-1:0]  grant_o
);

  localparam int unsigned IdW = id_width(N);

  int unsigned idx;

  always_comb begin
    any_o   = 1'b0;
    grant_o = '0;
    idx     = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (int'(last_i) + i) % N;
      if (!any_o && req_i[IdW'(idx)]) begin
        any_o   = 1'b1;
        grant_o = IdW'(idx);
      end
    end
  end

endmodule

// File: rtl/addsub_rr_scheduler.sv
// Time-shares one external 8-bit adder/subtractor among NUM_REQ requesters, one op in flight.
// Define ADDSUB_RR_SAT_EN to saturate on signed overflow and report res_ovf.
module addsub_rr_scheduler
  import addsub_rr_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  addsub_rr_scheduler_if.slave  bus
);

  localparam int unsigned IdW = id_width(NUM_REQ);
  localparam int unsigned Msb = DATA_W - 1;

  state_e               state_q, state_d;
  logic [IdW-1:0]       last_grant_q;
  logic [DATA_W-1:0]    a_q, b_q;
  logic                 sub_q;
  logic [DATA_W-1:0]    res_data_q, res_next;
  logic [IdW-1:0]       res_id_q;

  logic                 pick_any;
  logic [IdW-1:0]       pick;
  logic                 accept;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 res_valid;
  logic                 au_cin;
  logic [DATA_W-1:0]    au_i0, au_i1;

  rr_grant_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .req_i   (bus.req_valid),
    .last_i  (last_grant_q),
    .any_o   (pick_any),
    .grant_o (pick)
  );

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    req_ready = '0;
    res_valid = 1'b0;
    au_cin    = 1'b0;
    au_i0     = '0;
    au_i1     = '0;
    unique case (state_q)
      StIdle: begin
        if (pick_any && !rst) begin
          accept          = 1'b1;
          req_ready[pick] = 1'b1;
          state_d         = StCalc;
        end
      end
      StCalc: begin
        au_cin  = sub_q;
        au_i0   = a_q;
        au_i1   = b_q;
        state_d = StResp;
      end
      StResp: begin
        res_valid = 1'b1;
        if (bus.res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef ADDSUB_RR_SAT_EN
  logic [DATA_W-1:0] b_eff;
  logic              ovf, res_ovf_q;

  // Overflow: effective operands share a sign that the sum does not.
  always_comb begin
    b_eff    = sub_q ? ~b_q : b_q;
    ovf      = (a_q[Msb] == b_eff[Msb]) && (bus.au_sum[Msb] != a_q[Msb]);
    res_next = bus.au_sum;
    if (ovf) res_next = a_q[Msb] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_ovf_q <= 1'b0;
    end else if (state_q == StCalc) begin
      res_ovf_q <= ovf;
    end
  end

  assign bus.res_ovf = res_ovf_q;
`else
  assign res_next    = bus.au_sum;
  assign bus.res_ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= IdW'(NUM_REQ - 1);
      a_q          <= '0;
      b_q          <= '0;
      sub_q        <= 1'b0;
      res_data_q   <= '0;
      res_id_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q          <= bus.req_a[pick*DATA_W +: DATA_W];
        b_q          <= bus.req_b[pick*DATA_W +: DATA_W];
        sub_q        <= bus.req_sub[pick];
        last_grant_q <= pick;
      end
      if (state_q == StCalc) begin
        res_data_q <= res_next;
        res_id_q   <= last_grant_q;
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign bus.au_cin    = au_cin;
  assign bus.au_i0     = au_i0;
  assign bus.au_i1     = au_i1;

endmodule
